// File: rtl/v_mem_pkg.sv
// v_mem_pkg: shared element-width codes, lane index type and request record for the vector LSU and data memory
package v_mem_pkg;
  localparam logic [2:0] SEW8  = 3'b000;
  localparam logic [2:0] SEW16 = 3'b001;
  localparam logic [2:0] SEW32 = 3'b010;
  typedef logic [1:0] lane_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  vsew;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/v_lane_align.sv
// v_lane_align: maps MSB-justified elements to/from little-endian byte lanes and flags misaligned or reserved widths
module v_lane_align
  import v_mem_pkg::*;
(
  input  logic [2:0]  vsew,
  input  lane_t       lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);
  logic [31:0] shr;
  assign shr = rword >> {lane, 3'b000};
  // byte enables, replicated store data, justified load data and alignment error per element width
  always_comb begin
    be    = vsew == SEW8  ? 4'b0001 << lane :
            vsew == SEW16 ? (lane[1] ? 4'b1100 : 4'b0011) :
            vsew == SEW32 ? 4'b1111 : 4'b0000;
    wword = vsew == SEW8  ? {4{wdata[31:24]}} :
            vsew == SEW16 ? {2{wdata[31:16]}} : wdata;
    rdata = vsew == SEW8  ? {shr[7:0], 24'd0} :
            vsew == SEW16 ? {shr[15:0], 16'd0} : rword;
    err   = vsew == SEW8  ? 1'b0 :
            vsew == SEW16 ? lane[0] :
            vsew == SEW32 ? |lane : 1'b1;
  end
endmodule

// File: rtl/v_dmem_resp.sv
// v_dmem_resp: word-addressed data memory answering LSU element requests with a one-cycle registered response
module v_dmem_resp
  import v_mem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_vsew,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  req_t        req;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword, rword, rdata;
  logic        align_err, err, acc;
  assign req       = '{we: req_we, vsew: req_vsew, addr: req_addr, wdata: req_wdata};
  assign idx       = req.addr[AW+1:2];
  assign rword     = mem[idx];
  assign err       = align_err || (req.addr[31:2] >= 30'(DEPTH));
  assign req_ready = !nrst && (!rsp_valid || rsp_ready);
  assign acc       = req_valid && req_ready;
  v_lane_align u_align (
    .vsew  (req.vsew),
    .lane  (req.addr[1:0]),
    .wdata (req.wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rdata (rdata),
    .err   (align_err)
  );
  // store commits on the accept edge so a following load sees it without forwarding
  always_ff @(posedge clk)
    if (acc && req.we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  // response register and saturating error count
  always_ff @(posedge clk) begin
    if (nrst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (req.we || err) ? '0 : rdata;
      rsp_err   <= err;
      if (err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/v_dmem_resp.md
# v_dmem_resp

Memory-side responder for the vector load/store unit: accepts one element request per cycle over a valid/ready channel, performs a byte-lane read or read-modify-write on an internal word-addressed data memory, and returns a registered response. Store and load data use the LSU's MSB-justified element format on the bus and little-endian byte lanes inside the memory word. The block sits between the vector LSU and the vector data memory, and is the target end of the LSU's request interface.

## Interface
- DEPTH, 1024: number of 32-bit memory words. Must be a power of two.
- ERR_CNT_W, 16: width of the saturating error counter.
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  synchronous, active-high reset. Asserted = 1 resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_vsew  in  3  element width: 3'b000 = 8-bit, 3'b001 = 16-bit, 3'b010 = 32-bit; other values reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store element, MSB-justified (8-bit in [31:24], 16-bit in [31:16]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on an edge where rsp_valid && rsp_ready.
- rsp_rdata  out  32  load element, MSB-justified, with low bits zero. 0 for stores and errors.
- rsp_err  out  1  the request was misaligned, used a reserved vsew, or was out of range.
- err_cnt  out  ERR_CNT_W  count of errored requests; saturates at all-ones.

## Operation
- Word index is req_addr[31:2]. The byte at addr[1:0] = k occupies word bits [8k+7:8k].
- Error conditions (any one sets the error):
  - vsew is reserved;
  - vsew = 16-bit and addr[0] = 1;
  - vsew = 32-bit and addr[1:0] != 0;
  - word index >= DEPTH.
- Errored request: no memory write, rsp_rdata = 0, rsp_err = 1, err_cnt increments.
- Load, 8-bit: rsp_rdata = {word[8k+7:8k], 24'd0}.
- Load, 16-bit: rsp_rdata = {word[16h+15:16h], 16'd0}, where h = addr[1].
- Load, 32-bit: rsp_rdata = word.
- Store: writes only the addressed lanes.
  - 8-bit: lane k takes req_wdata[31:24].
  - 16-bit: lanes 2h and 2h+1 take req_wdata[31:16].
  - 32-bit: the whole word takes req_wdata.
  - Other lanes are unchanged.
  - The response is an ack: rsp_rdata = 0, rsp_err = 0.
- Memory contents are not reset; their value is undefined until first written.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_cnt = 0.
  - req_ready = 0 while nrst = 1.
  - No memory write occurs during reset.
- req_ready = !nrst && (!rsp_valid || rsp_ready). It is combinational from rsp_ready.
- Accept edge:
  - memory is read, or written, on this edge;
  - rsp_valid, rsp_rdata, rsp_err and err_cnt load on this same edge;
  - the response is visible in the following cycle.
  - Latency from accept to response is 1 cycle.
- Throughput is 1 request per cycle while rsp_ready = 1.
- While rsp_valid && !rsp_ready: the response holds stable and no request is accepted.
- An edge with a response consumed and no new accept clears rsp_valid.
- Simultaneous consume and accept: the new response replaces the old one and rsp_valid stays 1.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data. No forwarding path is needed, because the write commits at the store's accept edge.
- Reset mid-operation: a pending response is dropped, and nothing in flight is written.
- err_cnt increments only on accept edges, and holds at 2^ERR_CNT_W - 1.

## Structure
- Package v_mem_pkg holds:
  - SEW8 = 3'b000, SEW16 = 3'b001, SEW32 = 3'b010;
  - the byte-lane index typedef;
  - a struct for the request fields.
- The vector LSU uses the same package.
- Sub-module v_lane_align is purely combinational. It does:
  - byte enable generation;
  - store lane insertion (MSB-justified to lane position);
  - load extraction (lane position to MSB-justified);
  - alignment and vsew error detection.
- The top level holds the memory array, the response register, the handshake and err_cnt.

## Test plan
- Reset, then 32-bit store of 0xDEADBEEF at address 0x10, then 32-bit load at 0x10 with rsp_ready = 1:
  - store ack, then rsp_rdata = 0xDEADBEEF and rsp_err = 0;
  - one response per cycle.
- After the previous test, 8-bit store of 0xA5000000 at 0x12, then 32-bit load at 0x10 → 0xDEA5BEEF. Then 16-bit load at 0x12 → 0xDEA50000.
- Back-to-back 8-bit loads at 0x10–0x13 with rsp_ready = 1 → 0xEF000000, 0xBE000000, 0xA5000000, 0xDE000000 on four consecutive cycles.
- Hold rsp_ready = 0 for 3 cycles after one accept:
  - rsp_valid stays 1 and rsp_rdata stays stable;
  - req_ready = 0;
  - the next request is accepted on the edge where rsp_ready returns to 1.
- Error cases:
  - 16-bit load at 0x11;
  - 32-bit store at 0x12;
  - req_vsew = 3'b011;
  - address 4*DEPTH;
  - each gives rsp_err = 1 and rsp_rdata = 0, memory is unchanged, and err_cnt reaches 4.
- Assert nrst while rsp_valid = 1 with a store pending → next cycle rsp_valid = 0 and err_cnt = 0, and the pending store's target word is unchanged.
